// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan of a 4-digit, 7-segment display fed from a 16-entry
//   hex message ROM. Each digit slot is BLANK_CNT cycles with all anodes off.
//   This prevents ghosting between digits. The slot then has REFRESH_CNT
//   cycles with one anode on. A button (already debounced) scrolls the message
//   window by one character. The scroll takes effect only at a frame boundary,
//   so all four digits of a frame always use the same pointer.
//
//   Optional build macro: AUTO_SCROLL_EN -- adds a frame counter that also
//   requests a scroll step every AUTO_FRAMES frames.
//
// Ports
//   clk        in   system clock (rising edge)
//   reset      in   asynchronous reset, active low
//   debounce   in   debounced button level, clk-synchronous
//   char_data  in   [3:0] nibble returned by the message ROM for char_addr
//   char_addr  out  [3:0] message ROM address (registered)
//   an         out  [3:0] anodes, active low, an[0] = leftmost digit
//   seg        out  [6:0] segments {g,f,e,d,c,b,a}, active low
//   frame_tick out  1-cycle pulse in the last drive cycle of digit 3
module display_scan_ctrl #(
  parameter int REFRESH_CNT = 50000,
  parameter int BLANK_CNT   = 4,
  parameter int AUTO_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       debounce,
  input  logic [3:0] char_data,
  output logic [3:0] char_addr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  if (REFRESH_CNT < 2 || BLANK_CNT < 2 || AUTO_FRAMES < 1) begin : g_bad_param
    $error("display_scan_ctrl: REFRESH_CNT>=2, BLANK_CNT>=2, AUTO_FRAMES>=1");
  end

  localparam int RW = $clog2(REFRESH_CNT + 1);
  localparam int BW = $clog2(BLANK_CNT + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLANK_CNT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_CNT - 1);
  localparam logic [RW-1:0] R_PEN  = RW'(REFRESH_CNT - 2);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_bcnt;
  logic [RW-1:0]   r_dcnt;
  logic [1:0]      r_digit;
  logic [3:0]      r_ptr;
  logic            r_pend;
  logic            r_deb_q;
  logic [3:0]      r_char_addr;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_frame_tick;

  logic w_rise;
  logic w_step;

  assign w_rise = debounce & ~r_deb_q;

`ifdef AUTO_SCROLL_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(AUTO_FRAMES - 1);
  logic [FW-1:0] r_fcnt;
  logic          w_auto;

  // Auto and button requests merge: either one produces a single step.
  assign w_auto = r_frame_tick && (r_fcnt == F_LAST);
  assign w_step = r_frame_tick && (r_pend || w_auto);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_fcnt <= '0;
    else if (r_frame_tick) r_fcnt <= (r_fcnt == F_LAST) ? '0 : r_fcnt + 1'b1;
  end
`else
  assign w_step = r_frame_tick && r_pend;
`endif

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'h40;  4'h1: hex7seg = 7'h79;
      4'h2: hex7seg = 7'h24;  4'h3: hex7seg = 7'h30;
      4'h4: hex7seg = 7'h19;  4'h5: hex7seg = 7'h12;
      4'h6: hex7seg = 7'h02;  4'h7: hex7seg = 7'h78;
      4'h8: hex7seg = 7'h00;  4'h9: hex7seg = 7'h10;
      4'hA: hex7seg = 7'h08;  4'hB: hex7seg = 7'h03;
      4'hC: hex7seg = 7'h46;  4'hD: hex7seg = 7'h21;
      4'hE: hex7seg = 7'h06;  default: hex7seg = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_BLANK;
      r_bcnt       <= '0;
      r_dcnt       <= '0;
      r_digit      <= '0;
      r_ptr        <= '0;
      r_pend       <= 1'b0;
      r_deb_q      <= 1'b0;
      r_char_addr  <= '0;
      r_an         <= 4'b1111;
      r_seg        <= 7'h7F;
      r_frame_tick <= 1'b0;
    end else begin
      r_deb_q      <= debounce;
      r_frame_tick <= 1'b0;

      // The step happens at the edge that ends the frame_tick cycle. An edge
      // that arrives in that same cycle stays pending for the next frame.
      if (w_step) begin
        r_ptr  <= r_ptr + 4'd1;
        r_pend <= w_rise;
      end else if (w_rise) begin
        r_pend <= 1'b1;
      end

      case (r_state)
        S_BLANK: begin
          // Address goes out early in the blank so the async ROM data has
          // settled before it is latched into seg on entry to DRIVE.
          if (r_bcnt == '0) r_char_addr <= r_ptr + {2'b00, r_digit};
          if (r_bcnt == B_LAST) begin
            r_state <= S_DRIVE;
            r_bcnt  <= '0;
            r_dcnt  <= '0;
            r_an    <= ~(4'b0001 << r_digit);
            r_seg   <= hex7seg(char_data);
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        default: begin
          // Registered pulse: raise one cycle early so it is high in the last cycle.
          if (r_dcnt == R_PEN && r_digit == 2'd3) r_frame_tick <= 1'b1;
          if (r_dcnt == R_LAST) begin
            r_state <= S_BLANK;
            r_dcnt  <= '0;
            r_bcnt  <= '0;
            r_digit <= r_digit + 2'd1;
            r_an    <= 4'b1111;
            r_seg   <= 7'h7F;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign char_addr  = r_char_addr;
  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;
  localparam int RC = 4;
  localparam int BC = 2;
  localparam int AF = 2;
  localparam int P  = RC + BC;
  localparam int F  = 4 * P;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       debounce = 1'b0;
  logic [3:0] char_data, char_addr, an;
  logic [6:0] seg;
  logic       frame_tick;

  assign char_data = char_addr;   // ROM returns its address
  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_CNT(RC), .BLANK_CNT(BC), .AUTO_FRAMES(AF)) dut (
    .clk(clk), .reset(reset), .debounce(debounce), .char_data(char_data),
    .char_addr(char_addr), .an(an), .seg(seg), .frame_tick(frame_tick));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Active-low {g,f,e,d,c,b,a} glyphs written out from the segment drawings.
  logic [6:0] GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: cycle index since reset release, pointer per frame,
  // pending request, last debounce level.
  int t;
  int mptr;
  bit mpend;
  bit mprev;

  task automatic model_reset();
    t = 0; mptr = 0; mpend = 0; mprev = 0;
  endtask

  // mode 0: button idle, 1: sparse 1-cycle pulses, 2: random level, 3: held high
  task automatic run(input int ncyc, input int mode);
    for (int i = 0; i < ncyc; i++) begin
      int pos, dig, off;
      bit d, edge_seen, auto_req;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      pos = t % F; dig = pos / P; off = pos % P;
      e_an  = (off < BC) ? 4'hF : ~(4'b0001 << dig);
      e_seg = (off < BC) ? 7'h7F : GLYPH[(mptr + dig) % 16];
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("frame_tick", frame_tick, (pos == F - 1));
      if (off >= 1) chk("char_addr", char_addr, (mptr + dig) % 16);
      case (mode)
        1:       d = ($urandom_range(0, 19) == 0);
        2:       d = $urandom_range(0, 1);
        3:       d = 1'b1;
        default: d = 1'b0;
      endcase
      debounce  = d;
      edge_seen = d && !mprev;
      mprev     = d;
      if (pos == F - 1) begin
`ifdef AUTO_SCROLL_EN
        auto_req = (((t / F) + 1) % AF) == 0;
`else
        auto_req = 1'b0;
`endif
        if (mpend || auto_req) mptr = (mptr + 1) % 16;
        mpend = edge_seen;
      end else begin
        mpend = mpend | edge_seen;
      end
      t++;
      @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_addr", char_addr, 4'h0);
    reset = 1'b1;

    run(3 * F, 0);        // idle scan, pointer stays 0
    run(40 * F, 1);       // sparse pulses, many steps incl. 15 -> 0 wrap
    run(10 * F, 2);       // bursts of edges within frames
    run(F / 2, 0);
    run(4 * F, 3);        // held high: single step only
    run(2 * F, 0);
    run(20 * F, 1);

    // Walk to the middle of the digit-2 drive slot, then hit reset.
    debounce = 1'b0;
    for (int k = 0; k < F && !(((t % F) / P == 2) && ((t % F) % P == BC + 1)); k++)
      run(1, 0);
    chk("pre_rst_an", an, 4'b1011);
    reset = 1'b0;
    #1;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_tick", frame_tick, 1'b0);
    chk("mid_rst_addr", char_addr, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run(3 * F, 0);        // restart at digit 0 after a full blank, ptr 0
    run(10 * F, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_CNT, default 50000, clock cycles a digit is driven per slot (>=2).
REQ-002 Parameter BLANK_CNT, default 4, clock cycles all anodes are off before each digit slot (>=2).
REQ-003 Parameter AUTO_FRAMES, default 250, full frames between automatic scroll steps (>=1, only used under AUTO_SCROLL_EN).
REQ-004 clk  input  1  system clock, all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 debounce  input  1  debounced, clk-synchronous button level from the Debounce block.
REQ-007 char_data  input  4  hex nibble returned by the async message ROM for char_addr.
REQ-008 char_addr  output  4  message ROM address, registered.
REQ-009 an  output  4  digit anodes, active-low, registered, an[0] = leftmost digit.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 frame_tick  output  1  one-cycle pulse at the end of each digit-3 drive slot.

Function
REQ-012 FSM states BLANK and DRIVE; each has its own cycle counter, cleared on state entry.
REQ-013 BLANK: an=4'b1111, seg=7'h7F; lasts exactly BLANK_CNT cycles, then goes to DRIVE.
REQ-014 char_addr is loaded with (ptr + digit) mod 16 on the first BLANK cycle; 4-bit add wraps.
REQ-015 DRIVE: an drives only bit[digit] low; seg = hex7seg(char_data) is registered on the first DRIVE cycle and held; lasts exactly REFRESH_CNT cycles.
REQ-016 hex7seg: standard 0-F glyphs, active-low (0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110).
REQ-017 At DRIVE end, digit increments mod 4 and the FSM returns to BLANK; slot period = BLANK_CNT + REFRESH_CNT cycles; frame = 4 slots.
REQ-018 frame_tick = 1 for exactly the cycle DRIVE of digit 3 ends; 0 otherwise.
REQ-019 Button step: rising edge of debounce (registered previous value 0, current 1) sets the flag pend.
REQ-020 On frame_tick with pend=1: ptr <= ptr+1 (mod 16, 15 wraps to 0) and pend cleared in the same cycle.
REQ-021 Any number of edges within one frame yields exactly one step; an edge in the frame_tick cycle itself is kept pending for the next frame.
REQ-022 ptr never changes mid-frame; all four digits of a frame use the same ptr.
REQ-023 A debounce level held high produces no further steps after its single edge.

Reset
REQ-024 reset low asynchronously forces: state=BLANK, both counters=0, digit=0, ptr=0, pend=0, edge register=0, char_addr=0, an=4'b1111, seg=7'h7F, frame_tick=0.
REQ-025 Reset asserted mid-DRIVE blanks the display immediately; after release, operation restarts at digit 0 with a full BLANK_CNT blank.

Configuration
REQ-026 Macro AUTO_SCROLL_EN: when defined, a frame counter counts frame_ticks and sets pend every AUTO_FRAMES frames (counter reset to 0); button and auto requests merge into one step.
REQ-027 Without AUTO_SCROLL_EN, no frame counter exists and ptr advances only on button edges.

Verification (REFRESH_CNT=4, BLANK_CNT=2, AUTO_FRAMES=2, ROM returns char_addr as data)
REQ-028 Reset release, no button -> an cycles 1111x2, 1110x4, 1111x2, 1101x4, ... ; seg on digit 0 = 7'b1000000; frame_tick every 24 cycles.
REQ-029 One debounce pulse mid-frame -> next frame digits show 1,2,3,4; ptr unchanged until frame_tick.
REQ-030 Three debounce pulses in one frame -> ptr advances by exactly 1.
REQ-031 ptr=13, one step -> digits show E,F,0,1 (wrap-around).
REQ-032 Reset asserted during digit-2 DRIVE -> an=1111, seg=7F same cycle; after release, 2 blank cycles then digit 0 driven showing 0.
REQ-033 AUTO_SCROLL_EN defined, no button -> ptr increments every 2 frames; with AUTO_SCROLL_EN undefined -> ptr stays 0 indefinitely.
